// File: rtl/iir_out_capture.sv
// Capture sink for the IIR filter output: stores DEPTH samples after the filter is stable,
// tracks peak |din| and provides a 1-cycle-latency readback port once the capture is complete.
module iir_out_capture #(
  parameter int DW    = 24,
  parameter int DEPTH = 2048,
  parameter int AW    = 11
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [DW-1:0] din,
  input  logic          din_valid,
  input  logic          stable_in,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data,
  output logic          rd_valid,
  output logic [AW:0]   wr_cnt,
  output logic [DW-1:0] peak_abs,
  output logic [15:0]   drop_cnt,
  output logic          busy,
  output logic          capture_done
);

  typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DONE} state_t;

  localparam logic [DW:0] MAX_POS = {2'b00, {(DW-1){1'b1}}};
  localparam logic [AW:0] LAST    = (AW+1)'(DEPTH-1);

  state_t        state;
  logic [DW-1:0] mem [DEPTH];
  logic          we;
  logic [AW-1:0] wa;
  logic [DW:0]   abs_ext;
  logic [DW-1:0] abs_sat;
  logic          pk_pend;
  logic [DW-1:0] pk_cand;

  always_comb begin
    we = 1'b0;
    wa = wr_cnt[AW-1:0];
    case (state)
      ARMED: begin
        we = din_valid && stable_in && !start && !rst;
        wa = '0;
      end
      CAPTURE: we = din_valid && !start && !rst;
      default: we = 1'b0;
    endcase
    // |din| at DW+1 bits so that the most negative code does not wrap
    abs_ext = din[DW-1] ? -{din[DW-1], din} : {1'b0, din};
    abs_sat = (abs_ext > MAX_POS) ? MAX_POS[DW-1:0] : abs_ext[DW-1:0];
  end

  always_ff @(posedge clk) begin
    if (we) mem[wa] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      rd_data      <= '0;
      rd_valid     <= 1'b0;
      wr_cnt       <= '0;
      peak_abs     <= '0;
      drop_cnt     <= '0;
      busy         <= 1'b0;
      capture_done <= 1'b0;
      pk_pend      <= 1'b0;
      pk_cand      <= '0;
    end else begin
      rd_valid <= 1'b0;
      // Peak is folded in one cycle after the write, from a registered candidate
      pk_pend  <= we;
      pk_cand  <= abs_sat;
      if (pk_pend && (pk_cand > peak_abs)) peak_abs <= pk_cand;

      if (start) begin
        state        <= ARMED;
        wr_cnt       <= '0;
        peak_abs     <= '0;
        drop_cnt     <= '0;
        pk_pend      <= 1'b0;
        busy         <= 1'b1;
        capture_done <= 1'b0;
      end else begin
        case (state)
          IDLE: ;
          ARMED: begin
            if (din_valid && stable_in) begin
              state  <= CAPTURE;
              wr_cnt <= (AW+1)'(1);
            end
          end
          CAPTURE: begin
            if (din_valid) begin
              wr_cnt <= wr_cnt + (AW+1)'(1);
              if (wr_cnt == LAST) begin
                state        <= DONE;
                busy         <= 1'b0;
                capture_done <= 1'b1;
              end
            end
          end
          DONE: begin
            if (din_valid && (drop_cnt != '1)) drop_cnt <= drop_cnt + 16'd1;
            if (rd_en) begin
              rd_valid <= 1'b1;
              rd_data  <= mem[rd_addr];
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_iir_out_capture.sv
// Directed bench for iir_out_capture: readback data goes through an expected-value queue
// checked by a monitor on rd_valid; status outputs are checked directly.
module tb_iir_out_capture;

  localparam int DW    = 24;
  localparam int DEPTH = 2048;
  localparam int AW    = 11;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [DW-1:0] din;
  logic          din_valid;
  logic          stable_in;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic [AW:0]   wr_cnt;
  logic [DW-1:0] peak_abs;
  logic [15:0]   drop_cnt;
  logic          busy;
  logic          capture_done;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DW-1:0] mdl [DEPTH];
  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] exp_peak;

  iir_out_capture #(.DW(DW), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .din(din), .din_valid(din_valid),
    .stable_in(stable_in), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .rd_valid(rd_valid), .wr_cnt(wr_cnt), .peak_abs(peak_abs), .drop_cnt(drop_cnt),
    .busy(busy), .capture_done(capture_done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  function automatic logic [DW-1:0] pat_val(input int pat, input int k);
    logic [31:0] kk;
    kk = k;
    case (pat)
      0: return kk[DW-1:0];
      1: return (k == 0) ? 24'h3FFFFF : (k == 1) ? 24'hC00001 :
                (k == 2) ? 24'h800000 : 24'(kk & 32'hFF);
      2: return (k == 0) ? 24'h3FFFFF : (k == 1) ? 24'hC00001 : 24'((kk * 3) & 32'hFFFF);
      default: return 24'(kk + 32'h100000);
    endcase
  endfunction

  function automatic logic [DW-1:0] ref_abs(input logic [DW-1:0] x);
    if (x == 24'h800000) return 24'h7FFFFF;
    if (x[DW-1]) return (~x) + 24'd1;
    return x;
  endfunction

  task automatic feed(input int first, input int n, input int pat);
    logic [DW-1:0] v;
    for (int k = first; k < first + n; k++) begin
      v         = pat_val(pat, k);
      din       = v;
      din_valid = 1'b1;
      step();
      mdl[k] = v;
      if (ref_abs(v) > exp_peak) exp_peak = ref_abs(v);
    end
    din_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start    = 1'b0;
    exp_peak = '0;
  endtask

  task automatic rd(input int a);
    rd_en   = 1'b1;
    rd_addr = AW'(a);
    exp_q.push_back(mdl[a]);
    step();
    chk("rd_valid_after_rd_en", {31'd0, rd_valid}, 32'd1);
  endtask

  // Monitor: every readback beat is scored against the queued expectation
  always @(negedge clk) begin
    if (rd_valid) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL rd_unexpected: got rd_valid=1 data %0h required no read", rd_data);
      end else begin
        logic [DW-1:0] e;
        e = exp_q.pop_front();
        if (rd_data !== e) begin
          n_fail++;
          $display("FAIL rd_data: got %0h expected %0h", rd_data, e);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; start = 1'b0; din = 24'h5; din_valid = 1'b1; stable_in = 1'b1;
    rd_en = 1'b0; rd_addr = '0; exp_peak = '0;

    // T1 reset with din_valid asserted
    repeat (3) step();
    chk("rst_wr_cnt", 32'(wr_cnt), 32'd0);
    chk("rst_peak", 32'(peak_abs), 32'd0);
    chk("rst_drop", 32'(drop_cnt), 32'd0);
    chk("rst_flags", {28'd0, busy, capture_done, rd_valid, 1'b0}, 32'd0);
    chk("rst_rd_data", 32'(rd_data), 32'd0);
    rst = 1'b0; din_valid = 1'b0;
    step();
    chk("idle_busy", {31'd0, busy}, 32'd0);

    // T2 arm gating then ramp capture
    pulse_start();
    chk("armed_busy", {31'd0, busy}, 32'd1);
    stable_in = 1'b0; din = 24'd99; din_valid = 1'b1;
    repeat (5) step();
    din_valid = 1'b0;
    chk("unstable_ignored", 32'(wr_cnt), 32'd0);
    stable_in = 1'b1;
    feed(0, DEPTH, 0);
    chk("ramp_wr_cnt", 32'(wr_cnt), 32'(DEPTH));
    chk("ramp_done", {30'd0, capture_done, busy}, 32'd2);
    step();
    chk("ramp_peak", 32'(peak_abs), 32'(exp_peak));

    // T4 back-to-back readback
    rd(0); rd(1); rd(2047);
    rd_en = 1'b0;
    step();
    chk("rd_idle_after", {31'd0, rd_valid}, 32'd0);

    // T5 overflow beats after DONE
    din = 24'h123456; din_valid = 1'b1;
    repeat (10) step();
    din_valid = 1'b0;
    chk("drop_cnt", 32'(drop_cnt), 32'd10);
    chk("drop_wr_cnt", 32'(wr_cnt), 32'(DEPTH));
    rd(0); rd(2); rd(1000); rd(2047);
    rd_en = 1'b0;
    step();

    // start coincident with din_valid: sample must be discarded
    din = 24'h7777; din_valid = 1'b1;
    pulse_start();
    din_valid = 1'b0;
    chk("start_win_flags", {30'd0, busy, capture_done}, 32'd2);
    chk("start_win_wr_cnt", 32'(wr_cnt), 32'd0);
    chk("start_win_drop", 32'(drop_cnt), 32'd0);
    step();
    chk("start_win_peak", 32'(peak_abs), 32'd0);
    chk("start_win_armed", 32'(wr_cnt), 32'd0);

    // T3 peak with the most negative code
    feed(0, 2, 1);
    feed(2, 1, 1);
    chk("peak_partial", 32'(peak_abs), 32'h3FFFFF);
    feed(3, DEPTH - 3, 1);
    chk("peak_run_done", {31'd0, capture_done}, 32'd1);
    step();
    chk("peak_sat", 32'(peak_abs), 32'(exp_peak));
    rd(0); rd(1); rd(2); rd(3);
    rd_en = 1'b0;
    step();

    // T6 restart mid-run, with rd_en during CAPTURE
    pulse_start();
    feed(0, 300, 3);
    rd_en = 1'b1; rd_addr = 11'd5;
    step();
    rd_en = 1'b0;
    chk("rd_in_capture", {31'd0, rd_valid}, 32'd0);
    feed(300, 400, 3);
    chk("mid_wr_cnt", 32'(wr_cnt), 32'd700);
    pulse_start();
    chk("restart_wr_cnt", 32'(wr_cnt), 32'd0);
    chk("restart_peak", 32'(peak_abs), 32'd0);
    feed(0, DEPTH, 2);
    chk("run2_done", {30'd0, capture_done, busy}, 32'd2);
    step();
    chk("run2_peak", 32'(peak_abs), 32'h3FFFFF);
    chk("run2_drop", 32'(drop_cnt), 32'd0);
    rd(0); rd(1); rd(5); rd(699); rd(700); rd(2047);
    rd_en = 1'b0;
    repeat (2) step();
    chk("rd_queue_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
